// File: rtl/mult_share_arbiter_if.sv
// Lane/multiplier bundle for mult_share_arbiter: lane handshake and response, multiplier operands and product, status.
// The slave modport is the arbiter; the master modport is the lane/multiplier side.
interface mult_share_arbiter_if #(
    parameter int G_NUM_REQ      = 4,
    parameter int G_A_WIDTH      = 18,
    parameter int G_B_WIDTH      = 18,
    parameter int G_MULT_LATENCY = 3
);
    localparam int P_W   = G_A_WIDTH + G_B_WIDTH;
    localparam int CNT_W = $clog2(G_MULT_LATENCY + 3);

    logic                           en;
    logic [G_NUM_REQ-1:0]           req_valid;
    logic [G_NUM_REQ-1:0]           req_ready;
    logic [G_NUM_REQ*G_A_WIDTH-1:0] req_a;
    logic [G_NUM_REQ*G_B_WIDTH-1:0] req_b;
    logic [G_A_WIDTH-1:0]           mult_a;
    logic [G_B_WIDTH-1:0]           mult_b;
    logic [P_W-1:0]                 mult_p;
    logic [G_NUM_REQ-1:0]           rsp_valid;
    logic [P_W-1:0]                 rsp_p;
    logic [CNT_W-1:0]               inflight;
    logic                           busy;

    modport slave (
        input  en, req_valid, req_a, req_b, mult_p,
        output req_ready, mult_a, mult_b, rsp_valid, rsp_p, inflight, busy
    );

    modport master (
        output en, req_valid, req_a, req_b, mult_p,
        input  req_ready, mult_a, mult_b, rsp_valid, rsp_p, inflight, busy
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// Round-robin share of one pipelined multiplier among G_NUM_REQ lanes; products are returned tagged by lane.
// Latency: handshake at T -> rsp_valid/rsp_p at T+2+G_MULT_LATENCY; one issue per cycle sustained.
// Backpressure: req_ready is combinational (gated by en and rst); the response path has none, lanes must accept it.
module mult_share_arbiter #(
    parameter int G_NUM_REQ      = 4,
    parameter int G_A_WIDTH      = 18,
    parameter int G_B_WIDTH      = 18,
    parameter int G_MULT_LATENCY = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    mult_share_arbiter_if.slave  bus
);
    localparam int ID_W  = $clog2(G_NUM_REQ);
    localparam int P_W   = G_A_WIDTH + G_B_WIDTH;
    localparam int CNT_W = $clog2(G_MULT_LATENCY + 3);

    logic [G_A_WIDTH-1:0] lane_a [G_NUM_REQ];
    logic [G_B_WIDTH-1:0] lane_b [G_NUM_REQ];

    for (genvar i = 0; i < G_NUM_REQ; i++) begin : g_unpack
        assign lane_a[i] = bus.req_a[i*G_A_WIDTH +: G_A_WIDTH];
        assign lane_b[i] = bus.req_b[i*G_B_WIDTH +: G_B_WIDTH];
    end

    logic [ID_W-1:0]           ptr;
    logic [ID_W:0]             scan_idx;
    logic                      gnt_vld;
    logic [ID_W-1:0]           gnt_id;
    logic [G_NUM_REQ-1:0]      gnt;

    logic [G_A_WIDTH-1:0]      mult_a_r;
    logic [G_B_WIDTH-1:0]      mult_b_r;
    logic                      iss_vld;
    logic [ID_W-1:0]           iss_id;
    logic [G_MULT_LATENCY-1:0] tag_vld;
    logic [ID_W-1:0]           tag_id [G_MULT_LATENCY];
    logic [G_NUM_REQ-1:0]      rsp_valid_r;
    logic [P_W-1:0]            rsp_p_r;
    logic [CNT_W-1:0]          inflight_r;

    // First valid lane at or after ptr, wrapping modulo G_NUM_REQ.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_id   = '0;
        gnt      = '0;
        scan_idx = '0;
        for (int k = 0; k < G_NUM_REQ; k++) begin
            scan_idx = {1'b0, ptr} + (ID_W+1)'(k);
            if (scan_idx >= (ID_W+1)'(G_NUM_REQ))
                scan_idx = scan_idx - (ID_W+1)'(G_NUM_REQ);
            if (bus.en && !rst && !gnt_vld && bus.req_valid[scan_idx[ID_W-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_id  = scan_idx[ID_W-1:0];
            end
        end
        if (gnt_vld)
            gnt[gnt_id] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr         <= '0;
            mult_a_r    <= '0;
            mult_b_r    <= '0;
            iss_vld     <= 1'b0;
            iss_id      <= '0;
            tag_vld     <= '0;
            for (int i = 0; i < G_MULT_LATENCY; i++)
                tag_id[i] <= '0;
            rsp_valid_r <= '0;
            rsp_p_r     <= '0;
            inflight_r  <= '0;
        end else begin
            if (gnt_vld) begin
                ptr      <= (gnt_id == ID_W'(G_NUM_REQ-1)) ? '0 : gnt_id + ID_W'(1);
                mult_a_r <= lane_a[gnt_id];
                mult_b_r <= lane_b[gnt_id];
            end

            // Issue register travels with mult_a/mult_b; the pipe then matches the multiplier depth.
            iss_vld    <= gnt_vld;
            iss_id     <= gnt_id;
            tag_vld[0] <= iss_vld;
            tag_id[0]  <= iss_id;
            for (int i = 1; i < G_MULT_LATENCY; i++) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_id[i]  <= tag_id[i-1];
            end

            rsp_valid_r <= '0;
            if (tag_vld[G_MULT_LATENCY-1]) begin
                rsp_valid_r[tag_id[G_MULT_LATENCY-1]] <= 1'b1;
                rsp_p_r                               <= bus.mult_p;
            end

            case ({gnt_vld, |rsp_valid_r})
                2'b10:   inflight_r <= inflight_r + CNT_W'(1);
                2'b01:   inflight_r <= inflight_r - CNT_W'(1);
                default: inflight_r <= inflight_r;
            endcase
        end
    end

    assign bus.req_ready = gnt;
    assign bus.mult_a    = mult_a_r;
    assign bus.mult_b    = mult_b_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_p     = rsp_p_r;
    assign bus.inflight  = inflight_r;
    assign bus.busy      = (inflight_r != '0);
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: directed scenarios then random traffic, scoreboarded against a round-robin reference.
module tb_mult_share_arbiter;
    localparam int N  = 4;
    localparam int AW = 18;
    localparam int BW = 18;
    localparam int L  = 3;
    localparam int PW = AW + BW;

    typedef struct {
        int            lane;
        logic [PW-1:0] p;
        int            due;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_share_arbiter_if #(.G_NUM_REQ(N), .G_A_WIDTH(AW), .G_B_WIDTH(BW), .G_MULT_LATENCY(L)) bus ();

    mult_share_arbiter #(.G_NUM_REQ(N), .G_A_WIDTH(AW), .G_B_WIDTH(BW), .G_MULT_LATENCY(L)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Fixed-latency multiplier model: product of operands presented at cycle c appears at c+L.
    logic [PW-1:0] mpipe [L];
    always @(posedge clk) begin
        mpipe[0] <= PW'(bus.mult_a) * PW'(bus.mult_b);
        for (int i = 1; i < L; i++)
            mpipe[i] <= mpipe[i-1];
    end
    assign bus.mult_p = mpipe[L-1];

    int           total = 0;
    int           bad   = 0;
    int           cyc   = 0;
    int           mptr  = 0;
    int           exp_g;
    int           lidx;
    logic [N-1:0] exp_rdy;
    logic [N-1:0] hs_last = '0;
    exp_t         q[$];
    exp_t         e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor/scoreboard: reference arbitration, expected responses queued at grant time.
    always @(negedge clk) begin
        if (rst) begin
            check("rst_req_ready", 64'(bus.req_ready), 64'(0));
            check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
            check("rst_rsp_p", 64'(bus.rsp_p), 64'(0));
            check("rst_inflight", 64'(bus.inflight), 64'(0));
            check("rst_busy", 64'(bus.busy), 64'(0));
            q.delete();
            mptr    = 0;
            hs_last = '0;
        end else begin
            check("inflight", 64'(bus.inflight), 64'(q.size()));
            check("busy", 64'(bus.busy), 64'(q.size() != 0));
            if (q.size() > 0 && q[0].due == cyc) begin
                e = q.pop_front();
                check("rsp_valid", 64'(bus.rsp_valid), 64'(1) << e.lane);
                check("rsp_p", 64'(bus.rsp_p), 64'(e.p));
            end else begin
                check("rsp_idle", 64'(bus.rsp_valid), 64'(0));
            end

            exp_g = -1;
            if (bus.en) begin
                for (int k = 0; k < N; k++) begin
                    lidx = (mptr + k) % N;
                    if (exp_g < 0 && bus.req_valid[lidx])
                        exp_g = lidx;
                end
            end
            exp_rdy = '0;
            if (exp_g >= 0)
                exp_rdy[exp_g] = 1'b1;
            check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));

            if (exp_g >= 0) begin
                e.lane = exp_g;
                e.p    = PW'(bus.req_a[exp_g*AW +: AW]) * PW'(bus.req_b[exp_g*BW +: BW]);
                e.due  = cyc + 2 + L;
                q.push_back(e);
                mptr = (exp_g + 1) % N;
            end
            hs_last = bus.req_valid & bus.req_ready;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b);
        bus.req_a[i*AW +: AW] = a;
        bus.req_b[i*BW +: BW] = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        bus.en        = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        tick(2);
        rst = 1'b0;

        // Single lane 1: 3*5
        bus.en = 1'b1;
        set_op(1, 18'd3, 18'd5);
        bus.req_valid = 4'b0010;
        tick(1);
        bus.req_valid = '0;
        tick(8);

        // All lanes from reset: a=i+1, b=10
        do_reset();
        for (int i = 0; i < N; i++)
            set_op(i, AW'(i + 1), 18'd10);
        bus.req_valid = 4'b1111;
        tick(12);
        bus.req_valid = '0;
        tick(6);

        // Park pointer at 3 via lane 2, then only lanes 0 and 3 contend
        set_op(2, 18'd7, 18'd9);
        bus.req_valid = 4'b0100;
        tick(1);
        set_op(0, 18'd11, 18'd13);
        set_op(3, 18'd17, 18'd19);
        bus.req_valid = 4'b1001;
        tick(7);
        bus.req_valid = '0;
        tick(6);

        // en low with all lanes requesting: drain, then resume at saved pointer
        bus.req_valid = 4'b1111;
        tick(3);
        bus.en = 1'b0;
        tick(7);
        bus.en = 1'b1;
        tick(4);
        bus.req_valid = '0;
        tick(8);

        // Reset with three products in flight
        bus.req_valid = 4'b1111;
        tick(3);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(4);
        bus.req_valid = '0;
        tick(8);

        // Full-scale operands
        set_op(0, 18'h3FFFF, 18'h3FFFF);
        bus.req_valid = 4'b0001;
        tick(1);
        bus.req_valid = '0;
        tick(8);

        // Random traffic; a lane keeps valid and operands until its handshake
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!bus.req_valid[i] || hs_last[i]) begin
                    bus.req_valid[i] = ($urandom_range(0, 2) != 0);
                    set_op(i, AW'($urandom()), BW'($urandom()));
                end
            end
            bus.en = ($urandom_range(0, 7) != 0);
            if (c == 250) begin
                rst = 1'b1;
                tick(1);
                rst = 1'b0;
            end else begin
                tick(1);
            end
        end

        bus.req_valid = '0;
        bus.en        = 1'b1;
        tick(10);
        check("drained", 64'(q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
